// File: rtl/led_matrix_gray_if.sv
// rtl/led_matrix_gray_if.sv - host-side write/swap/intensity port of the grayscale LED matrix scanner
interface led_matrix_gray_if #(
  parameter int ROWS = 8,
  parameter int COLS = 4,
  parameter int BPP  = 2
);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic                 wr_en;
  logic [CW-1:0]        wr_col;
  logic [ROWS*BPP-1:0]  wr_data;
  logic                 swap;
  logic                 swap_pending;
  logic [3:0]           intensity;

  // Host side: pattern generator / loader drives writes, swap requests and brightness.
  modport master (
    output wr_en, wr_col, wr_data, swap, intensity,
    input  swap_pending
  );

  // Scanner side.
  modport slave (
    input  wr_en, wr_col, wr_data, swap, intensity,
    output swap_pending
  );
endinterface

// File: rtl/led_matrix_gray.sv
// rtl/led_matrix_gray.sv - double-buffered BPP-bit grayscale multiplexed LED matrix scanner (option LED_MATRIX_GRAY_BLANK_EN)
module led_matrix_gray #(
  parameter int ROWS    = 8,
  parameter int COLS    = 4,
  parameter int BPP     = 2,
  parameter int N       = 10,
  parameter int ROW_POL = 1,
  parameter int COL_POL = 1
) (
  input  logic                clk,
  input  logic                rst,
  led_matrix_gray_if.slave    host,
  output logic                frame_tick,
  output logic [ROWS-1:0]     rows,
  output logic [COLS-1:0]     cols
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PW = ROWS * BPP;
  localparam int S  = (1 << BPP) - 1;

  localparam logic            ROW_ON    = (ROW_POL != 0);
  localparam logic            COL_ON    = (COL_POL != 0);
  localparam logic [ROWS-1:0] ROWS_OFF  = {ROWS{~ROW_ON}};
  localparam logic [COLS-1:0] COLS_OFF  = {COLS{~COL_ON}};
  localparam logic [BPP-1:0]  SLOT_LAST = BPP'(S - 1);
  localparam logic [CW-1:0]   COL_LAST  = CW'(COLS - 1);

  // Scan position: prescaler inside a slot, gray slot inside a column, column inside a frame.
  logic [N-1:0]   presc_q, presc_d;
  logic [BPP-1:0] slot_q,  slot_d;
  logic [CW-1:0]  col_q,   col_d;

  // Two frame stores; front_q picks the one being displayed, the other takes host writes.
  logic [PW-1:0]  mem_q [2][COLS];
  logic           front_q, front_d;
  logic           pend_q,  pend_d;

  logic [ROWS-1:0] rows_q, rows_d;
  logic [COLS-1:0] cols_q, cols_d;

  logic presc_last, slot_last, col_last, frame_end;
  logic wr_ok;

  assign presc_last = (presc_q == {N{1'b1}});
  assign slot_last  = (slot_q == SLOT_LAST);
  assign col_last   = (col_q == COL_LAST);
  assign frame_end  = presc_last & slot_last & col_last;
  assign wr_ok      = host.wr_en && (int'(host.wr_col) < COLS);

  // frame_tick marks the last counter state of a frame; reset suppresses it.
  assign frame_tick        = frame_end & ~rst;
  assign host.swap_pending = pend_q;
  assign rows              = rows_q;
  assign cols              = cols_q;

  // Counter next state: presc wraps into slot, slot wraps into column.
  always_comb begin
    presc_d = presc_q + 1'b1;
    slot_d  = slot_q;
    col_d   = col_q;
    if (presc_last) begin
      slot_d = slot_last ? '0 : slot_q + 1'b1;
      if (slot_last) begin
        col_d = col_last ? '0 : col_q + 1'b1;
      end
    end
  end

  // Swap bookkeeping: a request is latched and only honoured at the frame boundary.
  always_comb begin
    front_d = front_q;
    pend_d  = pend_q;
    if (frame_end && (pend_q || host.swap)) begin
      front_d = ~front_q;
      pend_d  = 1'b0;
    end else if (host.swap) begin
      pend_d = 1'b1;
    end
  end

  // Pixel drive for the current counter state; becomes visible one clock later.
  always_comb begin
    logic [PW-1:0]   col_word;
    logic [ROWS-1:0] lit;
    logic [COLS-1:0] onehot;
    logic            gate_on;
    logic            blank;

    col_word = mem_q[front_q][col_q];
    lit      = '0;
    for (int r = 0; r < ROWS; r++) begin
      lit[r] = (col_word[r*BPP +: BPP] > slot_q);
    end

    gate_on = (presc_q[N-1 -: 4] <= host.intensity);
`ifdef LED_MATRIX_GRAY_BLANK_EN
    // Dark rows while the column drivers settle on a new column.
    blank = (slot_q == '0) && (presc_q < N'(4));
`else
    blank = 1'b0;
`endif

    rows_d = ROWS_OFF;
    if (gate_on && !blank) begin
      rows_d = ROW_ON ? lit : ~lit;
    end

    onehot        = '0;
    onehot[col_q] = 1'b1;
    cols_d        = COL_ON ? onehot : ~onehot;
  end

  // Counters, swap state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      slot_q  <= '0;
      col_q   <= '0;
      front_q <= 1'b0;
      pend_q  <= 1'b0;
      rows_q  <= ROWS_OFF;
      cols_q  <= COLS_OFF;
    end else begin
      presc_q <= presc_d;
      slot_q  <= slot_d;
      col_q   <= col_d;
      front_q <= front_d;
      pend_q  <= pend_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
    end
  end

  // Frame stores: host writes go to the buffer that is back in this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < COLS; c++) begin
          mem_q[b][c] <= '0;
        end
      end
    end else if (wr_ok) begin
      mem_q[~front_q][host.wr_col] <= host.wr_data;
    end
  end

endmodule

// File: tb/tb_led_matrix_gray.sv
// tb/tb_led_matrix_gray.sv - randomized model-checked bench for led_matrix_gray
module tb_led_matrix_gray;
  localparam int ROWS  = 8;
  localparam int COLS  = 4;
  localparam int BPP   = 2;
  localparam int N     = 4;
  localparam int S     = (1 << BPP) - 1;
  localparam int PS    = 1 << N;
  localparam int FRAME = COLS * S * PS;
`ifdef LED_MATRIX_GRAY_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            frame_tick;
  logic [ROWS-1:0] rows;
  logic [COLS-1:0] cols;

  led_matrix_gray_if #(.ROWS(ROWS), .COLS(COLS), .BPP(BPP)) bif ();

  led_matrix_gray #(
    .ROWS(ROWS), .COLS(COLS), .BPP(BPP), .N(N), .ROW_POL(1), .COL_POL(1)
  ) dut (
    .clk(clk), .rst(rst), .host(bif), .frame_tick(frame_tick), .rows(rows), .cols(cols)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit model_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: frame position, two frame stores, displayed-buffer index, pending flag.
  logic [ROWS*BPP-1:0] m_mem [2][COLS];
  int                  m_sel  = 0;
  int                  m_pend = 0;
  int                  m_pos  = 0;
  logic [ROWS-1:0]     m_rows = '0;
  logic [COLS-1:0]     m_cols = '0;

  task automatic model_step();
    int col, slot, presc;
    logic [ROWS*BPP-1:0] w;
    logic [BPP-1:0] px;
    logic [ROWS-1:0] nr;
    if (rst) begin
      for (int b = 0; b < 2; b++) for (int c = 0; c < COLS; c++) m_mem[b][c] = '0;
      m_sel = 0; m_pend = 0; m_pos = 0; m_rows = '0; m_cols = '0;
    end else begin
      col   = m_pos / (S * PS);
      slot  = (m_pos / PS) % S;
      presc = m_pos % PS;
      w     = m_mem[m_sel][col];
      nr    = '0;
      if (((presc >> (N - 4)) <= int'(bif.intensity)) && !(BLANK && slot == 0 && presc < 4)) begin
        for (int r = 0; r < ROWS; r++) begin
          px = w[r*BPP +: BPP];
          if (int'(px) > slot) nr[r] = 1'b1;
        end
      end
      m_rows = nr;
      m_cols = COLS'(1 << col);
      if (bif.wr_en && int'(bif.wr_col) < COLS) m_mem[1 - m_sel][bif.wr_col] = bif.wr_data;
      if (m_pos == FRAME - 1 && (m_pend != 0 || bif.swap)) begin
        m_sel = 1 - m_sel; m_pend = 0;
      end else if (bif.swap) begin
        m_pend = 1;
      end
      m_pos = (m_pos + 1) % FRAME;
    end
  endtask

  // Compare DUT with the model every cycle, then advance the model with this cycle's inputs.
  always @(negedge clk) begin
    if (model_on) begin
      chk("rows", rows, m_rows);
      chk("cols", cols, m_cols);
      chk("frame_tick", frame_tick, (!rst && m_pos == FRAME - 1));
      chk("swap_pending", bif.swap_pending, m_pend);
    end
    model_step();
  end

  task automatic wait_tick();
    for (int k = 0; k < 2 * FRAME + 10; k++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) return;
    end
    tests++; fails++;
    $display("FAIL wait_tick cycle %0d: got no frame_tick expected one within %0d", cyc, 2 * FRAME + 10);
  endtask

  task automatic idle_inputs();
    bif.wr_en = 1'b0; bif.wr_col = '0; bif.wr_data = '0; bif.swap = 1'b0;
  endtask

  // Gray pattern with row0=3, row1=1 seen in column 0 at counter index i.
  function automatic logic [7:0] gray_exp(input int i, input int inten);
    int presc;
    presc = i % PS;
    if (BLANK && i < 4) return 8'h00;
    if (presc > inten) return 8'h00;
    return (i < PS) ? 8'h03 : 8'h01;
  endfunction

  initial begin
    int t1, t2;
    bit found;
    rst = 1'b1;
    idle_inputs();
    bif.intensity = 4'd15;
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_on = 1'b1;
    chk("reset_rows", rows, 8'h00);
    chk("reset_cols", cols, 4'b0000);
    @(posedge clk); #1 rst = 1'b0;

    // Reset release, column dwell and frame period.
    t1 = -1; t2 = -1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (n == 2) begin
        chk("release_rows", rows, 8'h00);
        chk("release_cols", cols, 4'b0001);
      end
      if (n == 49) chk("dwell_end_col0", cols, 4'b0001);
      if (n == 50) chk("dwell_next_col1", cols, 4'b0010);
      if (frame_tick === 1'b1) begin
        if (t1 < 0) t1 = n;
        else if (t2 < 0) t2 = n;
      end
    end
    chk("first_tick", t1, 192);
    chk("tick_period", t2 - t1, 192);

    // Grayscale: column 0 row0=3 row1=1, swapped in mid-frame.
    @(posedge clk); #1;
    bif.wr_en = 1'b1; bif.wr_col = 2'd0; bif.wr_data = 16'h0007; bif.swap = 1'b1;
    @(posedge clk); #1 idle_inputs();
    @(negedge clk);
    chk("pending_after_swap", bif.swap_pending, 1);
    wait_tick();
    @(negedge clk);
    chk("pending_cleared", bif.swap_pending, 0);
    for (int i = 0; i < S * PS; i++) begin
      @(negedge clk);
      chk("gray_rows", rows, gray_exp(i, 15));
    end

    // Intensity 7: rows on for presc 0..7 only.
    @(posedge clk); #1 bif.intensity = 4'd7;
    wait_tick();
    @(negedge clk);
    for (int i = 0; i < S * PS; i++) begin
      @(negedge clk);
      chk("inten_rows", rows, gray_exp(i, 7));
    end
    @(posedge clk); #1 bif.intensity = 4'd15;

    // Swap raised on the frame_tick cycle itself, with a colliding write.
    found = 1'b0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      @(posedge clk); #1;
      if (frame_tick === 1'b1) begin
        bif.swap = 1'b1; bif.wr_en = 1'b1; bif.wr_col = 2'd1; bif.wr_data = 16'hFFFF;
        found = 1'b1;
        break;
      end
    end
    chk("tick_seen_for_swap", found, 1);
    @(posedge clk); #1 idle_inputs();
    @(negedge clk);
    chk("pending_on_tick_swap", bif.swap_pending, 0);

    // Reset 100 clocks into a frame with a swap pending.
    wait_tick();
    @(posedge clk); #1;
    bif.wr_en = 1'b1; bif.wr_col = 2'd2; bif.wr_data = 16'hAAAA; bif.swap = 1'b1;
    @(posedge clk); #1 idle_inputs();
    repeat (98) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_rows", rows, 8'h00);
    chk("midrst_cols", cols, 4'b0000);
    chk("midrst_pending", bif.swap_pending, 0);
    @(posedge clk); #1 bif.swap = 1'b1;
    @(posedge clk); #1 bif.swap = 1'b0;
    wait_tick();
    @(negedge clk);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (i % 37 == 0) chk("cleared_rows", rows, 8'h00);
    end

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      bif.wr_en   = ($urandom_range(0, 2) == 0);
      bif.wr_col  = 2'($urandom_range(0, COLS - 1));
      bif.wr_data = 16'($urandom);
      bif.swap    = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 150) == 0) bif.intensity = 4'($urandom);
      rst = ($urandom_range(0, 900) == 0);
    end
    @(posedge clk); #1 rst = 1'b0; idle_inputs();
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
